// File: rtl/video_trk_pkg.sv
// Shared constants for the video edge/frame tracker: channel roles and edge selects.
package video_trk_pkg;

  // Channel roles within ch_in; channels above CH_DE are generic flags.
  localparam int CH_VS = 0;
  localparam int CH_HS = 1;
  localparam int CH_DE = 2;

  // Edge selection for frame/line event generation.
  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;

endpackage

// File: rtl/edge_sync_1b.sv
// Single-bit synchroniser chain with one-cycle rise/fall pulses.
// The chain has SYNC_STAGES+1 flops. The last flop is only a delay tap,
// used to compare against the synchronised level for edge detection.
module edge_sync_1b #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES:0] s_q;
  logic [SYNC_STAGES:0] s_d;

  // Shift the raw input into the chain by one stage per clock.
  always_comb begin
    s_d = {s_q[SYNC_STAGES-1:0], din};
  end

  // Chain register; cleared on async reset so no phantom edges follow reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign level = s_q[SYNC_STAGES-1];
  assign rise  = s_q[SYNC_STAGES-1] & ~s_q[SYNC_STAGES];
  assign fall  = ~s_q[SYNC_STAGES-1] & s_q[SYNC_STAGES];

endmodule

// File: rtl/video_edge_tracker.sv
// Video sync tracker: per-channel edge pulses, modulo frame counting,
// line/pixel position, and per-frame active width/height measurement.
module video_edge_tracker
  import video_trk_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_MOD   = 5,
  parameter int FRAME_CNT_W = 3,
  parameter int FRAME_EDGE  = 0,
  parameter int LINE_EDGE   = 1,
  parameter int H_W         = 12,
  parameter int V_W         = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [NUM_CH-1:0]      ch_in,
  output logic [NUM_CH-1:0]      rise,
  output logic [NUM_CH-1:0]      fall,
  output logic                   frame_evt,
  output logic                   line_evt,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   frame_sel,
  output logic [V_W-1:0]         line_cnt,
  output logic [H_W-1:0]         pix_cnt,
  output logic [H_W-1:0]         h_active,
  output logic [V_W-1:0]         v_active,
  output logic                   meas_valid
);

  localparam logic [H_W-1:0]         H_MAX    = {H_W{1'b1}};
  localparam logic [V_W-1:0]         V_MAX    = {V_W{1'b1}};
  localparam logic [FRAME_CNT_W-1:0] FRM_LAST = FRAME_CNT_W'(FRAME_MOD - 1);

  logic [NUM_CH-1:0] s_level;
  logic              de_s;
  logic              de_fall;
  logic              line_hold;
  logic              unused_level;

  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   frame_sel_q, frame_sel_d;
  logic [V_W-1:0]         line_cnt_q, line_cnt_d;
  logic [H_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic [H_W-1:0]         h_active_q, h_active_d;
  logic [V_W-1:0]         v_active_q, v_active_d;
  logic [V_W-1:0]         v_acc_q, v_acc_d;
  logic                   line_has_de_q, line_has_de_d;
  logic                   first_frame_q, first_frame_d;
  logic                   meas_valid_q, meas_valid_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    edge_sync_1b #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (ch_in[i]),
      .level(s_level[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Only the data-enable level is consumed; the other taps exist per channel.
  assign unused_level = ^s_level;

  assign frame_evt = (FRAME_EDGE == EDGE_RISE) ? rise[CH_VS] : fall[CH_VS];
  assign line_evt  = (LINE_EDGE == EDGE_RISE) ? rise[CH_HS] : fall[CH_HS];
  assign de_s      = s_level[CH_DE];
  assign de_fall   = fall[CH_DE];

  // The current line counts as active if de was seen earlier or is high now.
  assign line_hold = line_has_de_q | de_s;

  // Next-state for counters and measurements; clr discards all updates.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    line_cnt_d    = line_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    h_active_d    = h_active_q;
    v_active_d    = v_active_q;
    v_acc_d       = v_acc_q;
    line_has_de_d = line_has_de_q;
    first_frame_d = first_frame_q;
    meas_valid_d  = meas_valid_q;

    if (clr) begin
      frame_cnt_d   = '0;
      line_cnt_d    = '0;
      pix_cnt_d     = '0;
      h_active_d    = '0;
      v_active_d    = '0;
      v_acc_d       = '0;
      line_has_de_d = 1'b0;
      first_frame_d = 1'b0;
      meas_valid_d  = 1'b0;
    end else begin
      // Width is captured from the pre-update count so the falling edge's
      // own clear/increment does not disturb it.
      if (de_fall) begin
        h_active_d = pix_cnt_q;
      end

      if (frame_evt || line_evt) begin
        pix_cnt_d = H_W'(de_s);
      end else if (de_s && (pix_cnt_q != H_MAX)) begin
        pix_cnt_d = pix_cnt_q + H_W'(1);
      end

      if (frame_evt) begin
        line_cnt_d = '0;
      end else if (line_evt && (line_cnt_q != V_MAX)) begin
        line_cnt_d = line_cnt_q + V_W'(1);
      end

      if (frame_evt || line_evt) begin
        line_has_de_d = 1'b0;
      end else if (de_s) begin
        line_has_de_d = 1'b1;
      end

      if (frame_evt) begin
        v_acc_d    = '0;
        v_active_d = (line_hold && (v_acc_q != V_MAX)) ? v_acc_q + V_W'(1) : v_acc_q;
      end else if (line_evt && line_hold && (v_acc_q != V_MAX)) begin
        v_acc_d = v_acc_q + V_W'(1);
      end

      // The first frame after reset/clr is partial, so validity waits for
      // the second frame event.
      if (frame_evt) begin
        frame_cnt_d   = (frame_cnt_q == FRM_LAST) ? '0 : frame_cnt_q + FRAME_CNT_W'(1);
        first_frame_d = 1'b1;
        if (first_frame_q) begin
          meas_valid_d = 1'b1;
        end
      end
    end

    frame_sel_d = (frame_cnt_d == '0);
  end

  // Counter and measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      frame_sel_q   <= 1'b1;
      line_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      v_acc_q       <= '0;
      line_has_de_q <= 1'b0;
      first_frame_q <= 1'b0;
      meas_valid_q  <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      frame_sel_q   <= frame_sel_d;
      line_cnt_q    <= line_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      v_acc_q       <= v_acc_d;
      line_has_de_q <= line_has_de_d;
      first_frame_q <= first_frame_d;
      meas_valid_q  <= meas_valid_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign frame_sel  = frame_sel_q;
  assign line_cnt   = line_cnt_q;
  assign pix_cnt    = pix_cnt_q;
  assign h_active   = h_active_q;
  assign v_active   = v_active_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: tb/tb_video_edge_tracker.sv
// Scoreboard bench for video_edge_tracker: structured and random video
// timing, with a cycle-level reference model built from sample history.
module tb_video_edge_tracker;

  localparam int NCH   = 4;
  localparam int ST    = 2;
  localparam int FMOD  = 5;
  localparam int FCW   = 3;
  localparam int FEDGE = 0;
  localparam int LEDGE = 1;
  localparam int HW    = 5;
  localparam int VW    = 4;
  localparam int PMAX  = (1 << HW) - 1;
  localparam int LMAX  = (1 << VW) - 1;

  typedef struct packed {
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic           fe;
    logic           le;
    logic [FCW-1:0] fcnt;
    logic           fsel;
    logic [VW-1:0]  lcnt;
    logic [HW-1:0]  pix;
    logic [HW-1:0]  hact;
    logic [VW-1:0]  vact;
    logic           meas;
  } obs_t;

  logic           clk;
  logic           rst_n;
  logic           clr;
  logic [NCH-1:0] ch_in;
  logic [NCH-1:0] rise, fall;
  logic           frame_evt, line_evt;
  logic [FCW-1:0] frame_cnt;
  logic           frame_sel;
  logic [VW-1:0]  line_cnt;
  logic [HW-1:0]  pix_cnt, h_active;
  logic [VW-1:0]  v_active;
  logic           meas_valid;

  video_edge_tracker #(
    .NUM_CH(NCH), .SYNC_STAGES(ST), .FRAME_MOD(FMOD), .FRAME_CNT_W(FCW),
    .FRAME_EDGE(FEDGE), .LINE_EDGE(LEDGE), .H_W(HW), .V_W(VW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ch_in(ch_in),
    .rise(rise), .fall(fall), .frame_evt(frame_evt), .line_evt(line_evt),
    .frame_cnt(frame_cnt), .frame_sel(frame_sel), .line_cnt(line_cnt),
    .pix_cnt(pix_cnt), .h_active(h_active), .v_active(v_active),
    .meas_valid(meas_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t           expq[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             cyc   = 0;

  // Requested input levels; applied at the next falling edge.
  logic [NCH-1:0] cur     = '0;
  logic           cur_rst = 1'b0;
  logic           cur_clr = 1'b0;
  bit             noise3  = 1'b1;

  // Reference model state: newest sample at hq[0].
  logic [NCH-1:0] hq[$];
  int m_fcnt, m_line, m_pix, m_hact, m_vacc, m_vact;
  bit m_lhd, m_seen, m_meas;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_zero_counters();
    m_fcnt = 0; m_line = 0; m_pix = 0; m_hact = 0; m_vacc = 0; m_vact = 0;
    m_lhd = 0; m_seen = 0; m_meas = 0;
  endtask

  // Advance the model by one clock edge and queue the outputs expected after it.
  task automatic model_step();
    logic [NCH-1:0] a, b, r, f;
    bit fe, le, de, hold;
    int o_pix, o_vacc;
    obs_t e;
    if (!rst_n) begin
      model_zero_counters();
      hq.delete();
      for (int i = 0; i <= ST; i++) hq.push_back('0);
    end else begin
      a = hq[ST-1];
      b = hq[ST];
      r = a & ~b;
      f = ~a & b;
      fe = (FEDGE == 1) ? r[0] : f[0];
      le = (LEDGE == 1) ? r[1] : f[1];
      de = a[2];
      if (clr) begin
        model_zero_counters();
      end else begin
        o_pix  = m_pix;
        o_vacc = m_vacc;
        hold   = m_lhd || de;
        if (f[2]) m_hact = o_pix;
        if (fe || le) m_pix = de ? 1 : 0;
        else if (de) m_pix = imin(o_pix + 1, PMAX);
        if (fe) m_line = 0;
        else if (le) m_line = imin(m_line + 1, LMAX);
        if (fe) begin
          m_vact = imin(o_vacc + (hold ? 1 : 0), LMAX);
          m_vacc = 0;
        end else if (le && hold) begin
          m_vacc = imin(o_vacc + 1, LMAX);
        end
        if (fe || le) m_lhd = 0;
        else if (de) m_lhd = 1;
        if (fe) begin
          m_fcnt = (m_fcnt + 1) % FMOD;
          if (m_seen) m_meas = 1;
          m_seen = 1;
        end
      end
      hq.push_front(ch_in);
      void'(hq.pop_back());
    end
    a = hq[ST-1];
    b = hq[ST];
    e.rise = a & ~b;
    e.fall = ~a & b;
    e.fe   = (FEDGE == 1) ? e.rise[0] : e.fall[0];
    e.le   = (LEDGE == 1) ? e.rise[1] : e.fall[1];
    e.fcnt = FCW'(m_fcnt);
    e.fsel = (m_fcnt == 0);
    e.lcnt = VW'(m_line);
    e.pix  = HW'(m_pix);
    e.hact = HW'(m_hact);
    e.vact = VW'(m_vact);
    e.meas = m_meas;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    if (noise3 && ($urandom_range(0, 7) == 0)) cur[3] = ~cur[3];
    ch_in = cur;
    clr   = cur_clr;
    rst_n = cur_rst;
    cyc++;
    model_step();
  endtask

  task automatic hold_n(int n);
    repeat (n) tick();
  endtask

  task automatic do_line(int hsw, int delen);
    cur[1] = 1'b1; hold_n(hsw);
    cur[1] = 1'b0; hold_n(2);
    if (delen > 0) begin
      cur[2] = 1'b1; hold_n(delen);
      cur[2] = 1'b0;
    end
    hold_n(3);
  endtask

  task automatic do_frame(int nl, int dfirst, int dlast, int delen, int hsw);
    cur[0] = 1'b1; hold_n(4);
    cur[0] = 1'b0; hold_n(3);
    for (int l = 1; l <= nl; l++)
      do_line(hsw, (l >= dfirst && l <= dlast) ? delen : 0);
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queue.
  initial begin
    obs_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        act = '{rise: rise, fall: fall, fe: frame_evt, le: line_evt,
                fcnt: frame_cnt, fsel: frame_sel, lcnt: line_cnt, pix: pix_cnt,
                hact: h_active, vact: v_active, meas: meas_valid};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got rise=%h fall=%h fe=%b le=%b fcnt=%0d fsel=%b lcnt=%0d pix=%0d hact=%0d vact=%0d meas=%b; want rise=%h fall=%h fe=%b le=%b fcnt=%0d fsel=%b lcnt=%0d pix=%0d hact=%0d vact=%0d meas=%b",
                   $time, act.rise, act.fall, act.fe, act.le, act.fcnt, act.fsel, act.lcnt,
                   act.pix, act.hact, act.vact, act.meas, e.rise, e.fall, e.fe, e.le,
                   e.fcnt, e.fsel, e.lcnt, e.pix, e.hact, e.vact, e.meas);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compares, required completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, df, dl;
    rst_n = 1'b0;
    clr   = 1'b0;
    ch_in = '0;
    for (int i = 0; i <= ST; i++) hq.push_back('0);
    model_zero_counters();

    // Reset, then a single isolated vsync pulse.
    cur_rst = 1'b0; hold_n(4);
    cur_rst = 1'b1; hold_n(3);
    cur[0] = 1'b1; hold_n(10);
    cur[0] = 1'b0; hold_n(10);

    // Three regular frames: 8 lines, de 20 cycles on lines 2..7.
    repeat (3) do_frame(8, 2, 7, 20, 2);

    // Frame event and line event in the same cycle with line_cnt at 7.
    do_frame(7, 1, 3, 5, 1);
    cur[0] = 1'b1; hold_n(3);
    cur[0] = 1'b0; cur[1] = 1'b1; hold_n(2);
    cur[1] = 1'b0; hold_n(4);

    // Saturation: long de and more lines than line_cnt can hold.
    do_frame(20, 1, 20, 40, 1);
    do_frame(3, 1, 3, 40, 2);

    // Reset asserted mid-line with a few lines counted.
    cur[0] = 1'b1; hold_n(3);
    cur[0] = 1'b0; hold_n(2);
    do_line(2, 6); do_line(2, 6); do_line(2, 6);
    cur[1] = 1'b1; cur[2] = 1'b1; hold_n(2);
    cur_rst = 1'b0; hold_n(3);
    cur_rst = 1'b1; cur[1] = 1'b0; hold_n(5);
    cur[2] = 1'b0; hold_n(3);
    repeat (2) do_frame(4, 2, 3, 9, 1);

    // Clear pulse while inputs keep toggling.
    do_line(1, 7);
    cur_clr = 1'b1; cur[1] = 1'b1; hold_n(2);
    cur[1] = 1'b0; cur[0] = 1'b1; hold_n(2);
    cur_clr = 1'b0; cur[0] = 1'b0; hold_n(3);
    repeat (2) do_frame(5, 1, 4, 12, 1);

    // Randomised frame timing, including short frames for modulo wrap.
    repeat (30) begin
      nl = $urandom_range(0, 18);
      df = $urandom_range(0, 6);
      dl = $urandom_range(df, 18);
      if ($urandom_range(0, 15) == 0) begin
        cur_clr = 1'b1; hold_n(1); cur_clr = 1'b0;
      end
      do_frame(nl, df, dl, $urandom_range(0, 40), $urandom_range(1, 3));
    end

    // Unstructured random inputs to hit coincident edges.
    repeat (600) begin
      cur = NCH'($urandom);
      cur_clr = ($urandom_range(0, 40) == 0);
      tick();
    end
    cur_clr = 1'b0;
    cur = '0;
    hold_n(5);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
